// File: rtl/mac_act_out_pkg.sv
// Shared widths and activation limits for the MAC datapath and its controller.
// No logic; constants and types only.
// Import with mac_act_out_pkg::* wherever accumulator or activation widths are needed.
package mac_act_out_pkg;
    localparam int ACC_W   = 21;
    localparam int ACT_W   = 8;
    localparam int ACT_MAX = 127;
    localparam int ACT_MIN = -128;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [ACT_W-1:0] act_t;
endpackage

// File: rtl/mac_act_out_fifo.sv
// Small DEPTH x W FIFO with occupancy count; head entry is read straight from storage flops.
// Latency: write at edge E appears at the head (if empty) right after E.
// Backpressure: push at full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module act_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    // Storage, pointers and count; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/mac_act_out.sv
// Rounding shift, optional ReLU and int8 saturation of MAC sums, buffered for the next layer.
// Latency: accept at E0 registers the shifted sum; FIFO write at E1, so out_valid rises after E1.
// Backpressure: acc_ready drops when buffered plus in-flight results would fill the FIFO.
module mac_act_out
    import mac_act_out_pkg::*;
#(
    parameter int SHIFT = 4,
    parameter int RELU  = 1,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [ACC_W-1:0] i_acc_in,
    input  logic             i_acc_valid,
    output logic             o_acc_ready,
    output logic [ACT_W-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_sat_seen,
    input  logic             i_clr_sat
);
    localparam int S1_W  = ACC_W + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    // Half an LSB of the shifted result, so the floor of the arithmetic shift rounds ties upward.
    localparam int BIAS_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
    localparam logic signed [S1_W-1:0] W_MAX = S1_W'(ACT_MAX);
    localparam logic signed [S1_W-1:0] W_MIN = S1_W'(ACT_MIN);

    logic signed [S1_W-1:0] w_biased;
    logic signed [S1_W-1:0] w_shifted;
    logic signed [S1_W-1:0] r_s1;
    logic                   r_s1_vld;
    logic                   w_accept;
    logic [ACT_W-1:0]       w_act;
    logic                   w_sat;
    logic [CNT_W-1:0]       w_count;
    logic [CNT_W:0]         w_occ;
    logic                   r_sat_seen;

    // Occupancy includes the result still in stage 1, so a granted accept always has a slot.
    assign w_occ       = {1'b0, w_count} + {{CNT_W{1'b0}}, r_s1_vld};
    assign o_acc_ready = w_occ < (CNT_W + 1)'(DEPTH);
    assign w_accept    = i_acc_valid && o_acc_ready;

    // One extra bit keeps the biased sum from wrapping at the positive accumulator limit.
    assign w_biased  = {i_acc_in[ACC_W-1], i_acc_in} + S1_W'(BIAS_I);
    assign w_shifted = w_biased >>> SHIFT;

    // Stage 1: capture the rounded, shifted sum on accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1 <= w_shifted;
            end
        end
    end

    // Stage 2: ReLU clamp (not a saturation), then clip to the int8 range.
    always_comb begin
        w_act = r_s1[ACT_W-1:0];
        w_sat = 1'b0;
        if ((RELU != 0) && (r_s1 < 0)) begin
            w_act = '0;
        end else if (r_s1 > W_MAX) begin
            w_act = ACT_W'(ACT_MAX);
            w_sat = 1'b1;
        end else if (r_s1 < W_MIN) begin
            w_act = ACT_W'(ACT_MIN);
            w_sat = 1'b1;
        end
    end

    // Sticky saturation flag; a new event wins over a same-cycle clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sat_seen <= 1'b0;
        end else if (r_s1_vld && w_sat) begin
            r_sat_seen <= 1'b1;
        end else if (i_clr_sat) begin
            r_sat_seen <= 1'b0;
        end
    end

    assign o_sat_seen = r_sat_seen;

    act_fifo #(
        .DEPTH (DEPTH),
        .W     (ACT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_s1_vld),
        .i_din   (w_act),
        .i_pop   (i_out_ready),
        .o_dout  (o_out_data),
        .o_count (w_count)
    );

    assign o_out_valid = (w_count != '0);
endmodule

// File: tb/tb_mac_act_out.sv
module tb_mac_act_out;
    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] acc_in;
    logic        acc_valid;
    logic        out_ready;
    logic        clr_sat;
    logic        acc_ready1, out_valid1, sat1;
    logic        acc_ready0, out_valid0, sat0;
    logic [7:0]  out_data1, out_data0;

    int n_cmp  = 0;
    int n_fail = 0;
    int got_q[$];
    int occ     = 0;
    int max_occ = 0;

    typedef struct {
        int acc;
        int e1;   // expected with ReLU
        int e0;   // expected without ReLU
        int s1;
        int s0;
    } vec_t;
    vec_t vt[14];

    always #5 clk = ~clk;

    mac_act_out #(.SHIFT(4), .RELU(1), .DEPTH(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_acc_in(acc_in), .i_acc_valid(acc_valid),
        .o_acc_ready(acc_ready1), .o_out_data(out_data1), .o_out_valid(out_valid1),
        .i_out_ready(out_ready), .o_sat_seen(sat1), .i_clr_sat(clr_sat)
    );

    mac_act_out #(.SHIFT(4), .RELU(0), .DEPTH(4)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_acc_in(acc_in), .i_acc_valid(acc_valid),
        .o_acc_ready(acc_ready0), .o_out_data(out_data0), .o_out_valid(out_valid0),
        .i_out_ready(out_ready), .o_sat_seen(sat0), .i_clr_sat(clr_sat)
    );

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Record handshakes that will complete at the coming edge, then step past it.
    task automatic cycle();
        if (acc_valid && acc_ready1) occ++;
        if (out_valid1 && out_ready) begin
            got_q.push_back(int'($signed(out_data1)));
            occ--;
        end
        if (occ > max_occ) max_occ = occ;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int guard;
        bit acc_now;

        vt[0]  = '{800,      50,   50,   0, 0};
        vt[1]  = '{-300,     0,    -19,  0, 0};
        vt[2]  = '{1048575,  127,  127,  1, 1};
        vt[3]  = '{-1048576, 0,    -128, 0, 1};
        vt[4]  = '{8,        1,    1,    0, 0};
        vt[5]  = '{7,        0,    0,    0, 0};
        vt[6]  = '{-8,       0,    0,    0, 0};
        vt[7]  = '{-9,       0,    -1,   0, 0};
        vt[8]  = '{2032,     127,  127,  0, 0};
        vt[9]  = '{2040,     127,  127,  1, 1};
        vt[10] = '{-2056,    0,    -128, 0, 0};
        vt[11] = '{-2057,    0,    -128, 0, 1};
        vt[12] = '{24,       2,    2,    0, 0};
        vt[13] = '{-24,      0,    -1,   0, 0};

        rst = 1'b1; acc_valid = 1'b0; acc_in = '0; out_ready = 1'b1; clr_sat = 1'b0;
        #12;
        check("rst_out_valid", int'(out_valid1), 0);
        check("rst_acc_ready", int'(acc_ready1), 1);
        check("rst_out_data",  int'(out_data1), 0);
        check("rst_sat_seen",  int'(sat1), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle();

        // Latency: accept at E0, visible after E1, popped at E2.
        acc_valid = 1'b1; acc_in = 21'd800;
        cycle();
        check("lat_e0_valid", int'(out_valid1), 0);
        acc_valid = 1'b0;
        cycle();
        check("lat_e1_valid", int'(out_valid1), 1);
        check("lat_e1_data",  int'($signed(out_data1)), 50);
        cycle();
        check("lat_e2_valid", int'(out_valid1), 0);
        got_q.delete();

        // Table of single transfers through both ReLU variants.
        for (int i = 0; i < 14; i++) begin
            clr_sat = 1'b1; acc_valid = 1'b1; acc_in = 21'(vt[i].acc);
            cycle();
            clr_sat = 1'b0; acc_valid = 1'b0;
            cycle();
            check($sformatf("vec%0d_valid", i), int'(out_valid1 & out_valid0), 1);
            check($sformatf("vec%0d_relu1", i), int'($signed(out_data1)), vt[i].e1);
            check($sformatf("vec%0d_relu0", i), int'($signed(out_data0)), vt[i].e0);
            check($sformatf("vec%0d_sat1", i),  int'(sat1), vt[i].s1);
            check($sformatf("vec%0d_sat0", i),  int'(sat0), vt[i].s0);
            cycle();
        end
        clr_sat = 1'b1; cycle(); clr_sat = 1'b0;

        // Sticky flag: set, clear, then set and clear on the same edge.
        acc_valid = 1'b1; acc_in = 21'h0FFFFF;
        cycle();
        acc_valid = 1'b0;
        cycle();
        check("sat_set", int'(sat1), 1);
        cycle();
        clr_sat = 1'b1; cycle(); clr_sat = 1'b0;
        check("sat_clr", int'(sat1), 0);
        acc_valid = 1'b1; acc_in = 21'h0FFFFF;
        cycle();
        acc_valid = 1'b0; clr_sat = 1'b1;
        cycle();
        clr_sat = 1'b0;
        check("sat_set_wins", int'(sat1), 1);
        cycle();
        clr_sat = 1'b1; cycle(); clr_sat = 1'b0;
        got_q.delete(); occ = 0; max_occ = 0;

        // Backpressure: six offers with the consumer stalled.
        out_ready = 1'b0; k = 0;
        for (int c = 0; c < 10; c++) begin
            acc_valid = (k < 6); acc_in = 21'(16 * (k + 1));
            acc_now = acc_valid && acc_ready1;
            cycle();
            if (acc_now) k++;
        end
        check("bp_accepted", k, 4);
        check("bp_acc_ready", int'(acc_ready1), 0);
        check("bp_head_hold", int'($signed(out_data1)), 1);
        out_ready = 1'b1; guard = 0;
        while ((got_q.size() < 6) && (guard < 40)) begin
            acc_valid = (k < 6); acc_in = 21'(16 * (k + 1));
            acc_now = acc_valid && acc_ready1;
            cycle();
            if (acc_now) k++;
            guard++;
        end
        acc_valid = 1'b0;
        check("bp_pop_count", got_q.size(), 6);
        for (int j = 0; j < got_q.size(); j++) check($sformatf("bp_pop%0d", j), got_q[j], j + 1);
        check("bp_max_occ", max_occ, 4);
        got_q.delete(); occ = 0; max_occ = 0;

        // Full FIFO, then continuous offers and pops for ten cycles.
        out_ready = 1'b0; k = 0; guard = 0;
        while ((k < 4) && (guard < 20)) begin
            acc_valid = 1'b1; acc_in = 21'(16 * (11 + k));
            acc_now = acc_valid && acc_ready1;
            cycle();
            if (acc_now) k++;
            guard++;
        end
        acc_valid = 1'b0; cycle();
        check("full_valid", int'(out_valid1), 1);
        check("full_acc_ready", int'(acc_ready1), 0);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            acc_valid = 1'b1; acc_in = 21'(16 * (11 + k));
            acc_now = acc_valid && acc_ready1;
            cycle();
            if (acc_now) k++;
        end
        acc_valid = 1'b0; guard = 0;
        while ((got_q.size() < k) && (guard < 30)) begin
            cycle();
            guard++;
        end
        check("full_pop_count", got_q.size(), k);
        for (int j = 0; j < got_q.size(); j++) check($sformatf("full_pop%0d", j), got_q[j], 11 + j);
        check("full_max_occ", max_occ, 4);
        got_q.delete();

        // Reset with two buffered results and one in flight.
        out_ready = 1'b0;
        acc_valid = 1'b1;
        acc_in = 21'(16 * 90); cycle();
        acc_in = 21'(16 * 91); cycle();
        acc_in = 21'(16 * 92); cycle();
        acc_valid = 1'b0;
        check("pre_rst_valid", int'(out_valid1), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(out_valid1), 0);
        check("mid_rst_acc_ready", int'(acc_ready1), 1);
        check("mid_rst_out_data",  int'(out_data1), 0);
        @(posedge clk); #1;
        rst = 1'b0; occ = 0; got_q.delete();
        out_ready = 1'b1;
        repeat (3) cycle();
        check("post_rst_no_stale", got_q.size(), 0);
        acc_valid = 1'b1; acc_in = 21'(16 * 77);
        cycle();
        acc_valid = 1'b0;
        cycle();
        check("post_rst_data", int'($signed(out_data1)), 77);
        cycle();
        check("post_rst_pops", got_q.size(), 1);
        if (got_q.size() > 0) check("post_rst_pop0", got_q[0], 77);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "simulation did not complete");
    end
endmodule
